// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared definitions for the Sobel line scheduler.
//   - sched_state_e : scheduler FSM encoding (IDLE/FILL0/FILL1/RUN)
//   - NUM_BANKS     : number of line-buffer banks in the rotation (3)
//   - bank_mod_add  : (bank + step) mod NUM_BANKS for 2-bit bank indices
// -----------------------------------------------------------------------------
package video_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL0 = 2'd1,
        FILL1 = 2'd2,
        RUN   = 2'd3
    } sched_state_e;

    localparam logic [1:0] NUM_BANKS = 2'd3;

    // Modular add on bank indices; both operands are expected in 0..2.
    function automatic logic [1:0] bank_mod_add(input logic [1:0] bank,
                                                input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, bank} + {1'b0, step};
        if (sum >= {1'b0, NUM_BANKS}) begin
            sum = sum - {1'b0, NUM_BANKS};
        end else begin
            sum = sum;
        end
        return sum[1:0];
    endfunction

endpackage

// File: rtl/line_bank_rot.sv
// -----------------------------------------------------------------------------
// line_bank_rot
// Three-bank line-buffer rotation. The write bank advances once per completed
// line; the two read banks hold the previous two lines.
// Ports:
//   video_clk        : pixel clock, rising edge
//   rst              : asynchronous active-high reset
//   clear            : return the write bank to 0 (frame start)
//   advance          : step the write bank (end of a line)
//   wr_bank [1:0]    : bank currently being written (row N)
//   top_bank [1:0]   : bank holding row N-2, (wr_bank+1) mod 3
//   mid_bank [1:0]   : bank holding row N-1, (wr_bank+2) mod 3
// -----------------------------------------------------------------------------
module line_bank_rot
    import video_pkg::*;
(
    input  logic       video_clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       advance,
    output logic [1:0] wr_bank,
    output logic [1:0] top_bank,
    output logic [1:0] mid_bank
);

    logic [1:0] bank_r;

    // Write-bank register: clear wins over advance
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            bank_r <= 2'd0;
        end else if (clear) begin
            bank_r <= 2'd0;
        end else if (advance) begin
            bank_r <= bank_mod_add(bank_r, 2'd1);
        end else begin
            bank_r <= bank_r;
        end
    end

    assign wr_bank  = bank_r;
    assign top_bank = bank_mod_add(bank_r, 2'd1);
    assign mid_bank = bank_mod_add(bank_r, 2'd2);

endmodule

// File: rtl/sobel_line_sched.sv
// -----------------------------------------------------------------------------
// sobel_line_sched
// Line-buffer scheduler for a 3x3 Sobel window. Tracks column/line position
// from vs/de, drives the line-buffer write port, selects the two read banks
// and flags when the 3x3 window is valid and when it touches a frame edge.
//
// Optional feature: define SOBEL_SCHED_LINE_CHECK_EN to enable line-length
// checking (sticky line_err, column saturation and write suppression on
// overlong lines). Without it, line_err is 0 and col wraps after H_SIZE-1.
//
// Parameters: H_SIZE (pixels/line), V_SIZE (lines/frame),
//             ADDR_W (column width, at least clog2(H_SIZE+1))
// Ports:
//   video_clk, rst        : pixel clock, asynchronous active-high reset
//   vs, de                : frame sync and pixel valid
//   wr_en/wr_bank/wr_addr : line-buffer write strobe, bank, column
//   rd_addr, top_bank, mid_bank : read column and banks for rows N-2 / N-1
//   win_valid, border     : window usable / window on a frame edge
//   frame_done            : one-cycle pulse at the end of a complete frame
//   line_err              : sticky line-length error
//   state                 : FSM state (debug)
// -----------------------------------------------------------------------------
module sobel_line_sched
    import video_pkg::*;
#(
    parameter int H_SIZE = 1024,
    parameter int V_SIZE = 768,
    parameter int ADDR_W = 11
) (
    input  logic              video_clk,
    input  logic              rst,
    input  logic              vs,
    input  logic              de,
    output logic              wr_en,
    output logic [1:0]        wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        top_bank,
    output logic [1:0]        mid_bank,
    output logic              win_valid,
    output logic              border,
    output logic              frame_done,
    output logic              line_err,
    output logic [1:0]        state
);

    localparam int                LINE_W   = $clog2(V_SIZE + 1);
    localparam logic [ADDR_W-1:0] COL_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] H_LAST   = ADDR_W'(H_SIZE - 1);
    localparam logic [LINE_W-1:0] V_LAST   = LINE_W'(V_SIZE - 1);
    localparam logic [LINE_W-1:0] LINE_TWO = LINE_W'(2);
`ifdef SOBEL_SCHED_LINE_CHECK_EN
    localparam logic [ADDR_W-1:0] H_FULL   = ADDR_W'(H_SIZE);
`endif

    sched_state_e      state_r;
    sched_state_e      state_nxt_s;
    logic              vs_r;
    logic              de_r;
    logic [ADDR_W-1:0] col_r;
    logic [ADDR_W-1:0] col_nxt_s;
    logic [LINE_W-1:0] line_r;

    logic              frame_start_s;
    logic              de_fall_s;
    logic              active_s;
    logic              run_s;
    logic              pix_s;
    logic              line_adv_s;
    logic              last_line_s;
    logic              frame_end_s;
    logic              overrun_s;
    logic              wr_en_nxt_s;
    logic              win_nxt_s;
    logic              border_nxt_s;

    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic              win_valid_r;
    logic              border_r;
    logic              frame_done_r;

    // Edge-detect registers for vs and de
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            vs_r <= 1'b0;
            de_r <= 1'b0;
        end else begin
            vs_r <= vs;
            de_r <= de;
        end
    end

    assign frame_start_s = vs & ~vs_r;
    assign de_fall_s     = de_r & ~de;
    // A frame start on the same cycle as a de fall aborts the line instead of completing it
    assign line_adv_s    = de_fall_s & active_s & ~frame_start_s;
    assign last_line_s   = (line_r == V_LAST);
    assign frame_end_s   = run_s & line_adv_s & last_line_s;
    assign pix_s         = de & active_s;

    // FSM state register
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: frame start from any state, otherwise advance per completed line
    always_comb begin
        state_nxt_s = state_r;
        if (frame_start_s) begin
            state_nxt_s = FILL0;
        end else if (line_adv_s) begin
            case (state_r)
                FILL0:   state_nxt_s = FILL1;
                FILL1:   state_nxt_s = RUN;
                RUN:     state_nxt_s = last_line_s ? IDLE : RUN;
                default: state_nxt_s = state_r;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM output decode
    always_comb begin
        active_s = (state_r != IDLE);
        run_s    = (state_r == RUN);
    end

    // Overlong-pixel detection (only meaningful with line checking)
    always_comb begin
`ifdef SOBEL_SCHED_LINE_CHECK_EN
        overrun_s = pix_s & (col_r == H_FULL);
`else
        overrun_s = 1'b0;
`endif
    end

    // Column next value: cleared at line end / frame start, saturates or wraps at the line end
    always_comb begin
        col_nxt_s = col_r;
        if (frame_start_s || line_adv_s) begin
            col_nxt_s = COL_ZERO;
        end else if (pix_s) begin
`ifdef SOBEL_SCHED_LINE_CHECK_EN
            if (overrun_s) begin
                col_nxt_s = col_r;
            end else begin
                col_nxt_s = col_r + ADDR_W'(1);
            end
`else
            if (col_r == H_LAST) begin
                col_nxt_s = COL_ZERO;
            end else begin
                col_nxt_s = col_r + ADDR_W'(1);
            end
`endif
        end else begin
            col_nxt_s = col_r;
        end
    end

    // Column and line position counters
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            col_r  <= COL_ZERO;
            line_r <= {LINE_W{1'b0}};
        end else begin
            col_r <= col_nxt_s;
            if (frame_start_s) begin
                line_r <= {LINE_W{1'b0}};
            end else if (line_adv_s) begin
                line_r <= line_r + LINE_W'(1);
            end else begin
                line_r <= line_r;
            end
        end
    end

    // Window qualifiers computed from the pre-increment column, registered with wr_en
    always_comb begin
        wr_en_nxt_s  = pix_s & ~overrun_s;
        win_nxt_s    = wr_en_nxt_s & run_s;
        border_nxt_s = win_nxt_s & ((col_r == COL_ZERO) || (col_r == H_LAST) ||
                                    (line_r == LINE_TWO));
    end

    // Registered write/read port and status outputs
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            wr_en_r      <= 1'b0;
            wr_addr_r    <= COL_ZERO;
            rd_addr_r    <= COL_ZERO;
            win_valid_r  <= 1'b0;
            border_r     <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            wr_en_r      <= wr_en_nxt_s;
            wr_addr_r    <= col_r;
            rd_addr_r    <= col_r;
            win_valid_r  <= win_nxt_s;
            border_r     <= border_nxt_s;
            frame_done_r <= frame_end_s;
        end
    end

`ifdef SOBEL_SCHED_LINE_CHECK_EN
    logic short_s;
    logic line_err_r;

    assign short_s = line_adv_s & (col_r != H_FULL);

    // Sticky line-length error, cleared only by a new frame
    always_ff @(posedge video_clk or posedge rst) begin
        if (rst) begin
            line_err_r <= 1'b0;
        end else if (frame_start_s) begin
            line_err_r <= 1'b0;
        end else if (overrun_s || short_s) begin
            line_err_r <= 1'b1;
        end else begin
            line_err_r <= line_err_r;
        end
    end

    assign line_err = line_err_r;
`else
    assign line_err = 1'b0;
`endif

    line_bank_rot u_bank_rot (
        .video_clk (video_clk),
        .rst       (rst),
        .clear     (frame_start_s),
        .advance   (line_adv_s),
        .wr_bank   (wr_bank),
        .top_bank  (top_bank),
        .mid_bank  (mid_bank)
    );

    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign rd_addr    = rd_addr_r;
    assign win_valid  = win_valid_r;
    assign border     = border_r;
    assign frame_done = frame_done_r;
    assign state      = state_r;

endmodule

// File: tb/tb_sobel_line_sched.sv
// -----------------------------------------------------------------------------
// tb_sobel_line_sched
// Self-checking bench for sobel_line_sched with H_SIZE=8, V_SIZE=4.
// The reference model works at line/pixel level: it knows how many pixels it
// drives on each line and derives every expected output from the frame
// position (line index, pixel index) rather than from cycle-level state.
// -----------------------------------------------------------------------------
module tb_sobel_line_sched;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 4;

    logic          video_clk = 1'b0;
    logic          rst;
    logic          vs;
    logic          de;
    logic          wr_en;
    logic [1:0]    wr_bank;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [1:0]    top_bank;
    logic [1:0]    mid_bank;
    logic          win_valid;
    logic          border;
    logic          frame_done;
    logic          line_err;
    logic [1:0]    state;

    sobel_line_sched #(.H_SIZE(H), .V_SIZE(V), .ADDR_W(AW)) dut (
        .video_clk  (video_clk),
        .rst        (rst),
        .vs         (vs),
        .de         (de),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .top_bank   (top_bank),
        .mid_bank   (mid_bank),
        .win_valid  (win_valid),
        .border     (border),
        .frame_done (frame_done),
        .line_err   (line_err),
        .state      (state)
    );

    always #5 video_clk = ~video_clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model: frame position only
    bit m_active = 1'b0;   // inside a frame (after frame start, before last line)
    int m_lines  = 0;      // completed lines since the last frame start
    bit m_err    = 1'b0;

    int win_seen  = 0;
    int done_seen = 0;

    // Observed pulse counters for window-length and frame_done checks
    always @(negedge video_clk) begin
        if (win_valid === 1'b1) win_seen++;
        if (frame_done === 1'b1) done_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_state();
        if (!m_active) return 0;
        if (m_lines == 0) return 1;
        if (m_lines == 1) return 2;
        return 3;
    endfunction

    // Column reached after i pixels of a line
    function automatic int colf(input int i);
`ifdef SOBEL_SCHED_LINE_CHECK_EN
        return (i < H) ? i : H;
`else
        return i % H;
`endif
    endfunction

    function automatic bit wr_ok(input int i);
`ifdef SOBEL_SCHED_LINE_CHECK_EN
        return (i < H);
`else
        return (i >= 0);
`endif
    endfunction

    task automatic check_common();
        check_eq("state", state, exp_state());
        check_eq("wr_bank", wr_bank, m_lines % 3);
        check_eq("top_bank", top_bank, (m_lines + 1) % 3);  // row N-2
        check_eq("mid_bank", mid_bank, (m_lines + 2) % 3);  // row N-1
        check_eq("line_err", line_err, m_err);
    endtask

    task automatic pixel_checks(input int i);
        bit w;
        bit wv;
        int a;
        w = m_active && wr_ok(i);
        a = m_active ? colf(i) : 0;
`ifdef SOBEL_SCHED_LINE_CHECK_EN
        if (m_active && i >= H) m_err = 1'b1;
`endif
        wv = w && (m_lines >= 2);
        check_eq("wr_en", wr_en, w);
        check_eq("wr_addr", wr_addr, a);
        check_eq("rd_addr", rd_addr, a);
        check_eq("win_valid", win_valid, wv);
        check_eq("border", border, wv && (a == 0 || a == H - 1 || m_lines == 2));
        check_eq("frame_done_px", frame_done, 0);
        check_common();
    endtask

    task automatic idle(input int k);
        for (int c = 0; c < k; c++) begin
            @(negedge video_clk);
            check_eq("wr_en_idle", wr_en, 0);
            check_eq("wr_addr_idle", wr_addr, 0);
            check_eq("win_idle", win_valid, 0);
            check_eq("border_idle", border, 0);
            check_eq("frame_done_idle", frame_done, 0);
            check_common();
        end
    endtask

    // Drop de after n pixels and check the line-end cycle
    task automatic line_end(input int n);
        bit done;
        int a;
        de = 1'b0;
        @(negedge video_clk);
        done = 1'b0;
        a = 0;
        if (m_active) begin
            a = colf(n);
`ifdef SOBEL_SCHED_LINE_CHECK_EN
            if (n != H) m_err = 1'b1;
`endif
            m_lines++;
            if (m_lines == V) begin
                m_active = 1'b0;
                done = 1'b1;
            end
        end
        check_eq("wr_en_end", wr_en, 0);
        check_eq("wr_addr_end", wr_addr, a);
        check_eq("win_end", win_valid, 0);
        check_eq("frame_done", frame_done, done);
        check_common();
    endtask

    task automatic send_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            de = 1'b1;
            @(negedge video_clk);
            pixel_checks(i);
        end
    endtask

    task automatic send_line(input int n, input int gap);
        send_pixels(n);
        line_end(n);
        idle(gap);
    endtask

    task automatic frame_start();
        vs = 1'b1;
        @(negedge video_clk);
        vs = 1'b0;
        m_active = 1'b1;
        m_lines  = 0;
        m_err    = 1'b0;
        check_eq("fs_state", state, 1);
        check_eq("fs_wr_en", wr_en, 0);
        check_eq("fs_wr_addr", wr_addr, 0);
        check_eq("fs_done", frame_done, 0);
        check_common();
    endtask

    task automatic full_frame();
        for (int l = 0; l < V; l++) send_line(H, 2);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_state", state, 0);
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_wr_bank", wr_bank, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_rd_addr", rd_addr, 0);
        check_eq("rst_win", win_valid, 0);
        check_eq("rst_border", border, 0);
        check_eq("rst_done", frame_done, 0);
        check_eq("rst_err", line_err, 0);
        check_eq("rst_top", top_bank, 1);
        check_eq("rst_mid", mid_bank, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int d0;
        rst = 1'b1;
        vs  = 1'b0;
        de  = 1'b0;
        @(negedge video_clk);
        @(negedge video_clk);
        check_reset_outputs();
        rst = 1'b0;
        idle(2);

        // de in IDLE is ignored
        send_line(5, 2);

        // Full frame: banks, window length, borders, single frame_done
        w0 = win_seen;
        d0 = done_seen;
        frame_start();
        full_frame();
        idle(3);
        check_eq("win_cycles", win_seen - w0, 2 * H);
        check_eq("done_pulses", done_seen - d0, 1);

        // Abort in line 3 column 4, frame start coinciding with the de fall
        d0 = done_seen;
        frame_start();
        for (int l = 0; l < 3; l++) send_line(H, 1);
        send_pixels(4);
        de = 1'b0;
        vs = 1'b1;
        @(negedge video_clk);
        vs = 1'b0;
        m_active = 1'b1;
        m_lines  = 0;
        m_err    = 1'b0;
        check_eq("abort_state", state, 1);
        check_eq("abort_wr_addr", wr_addr, 4);
        check_eq("abort_wr_en", wr_en, 0);
        check_common();
        idle(2);
        check_eq("abort_no_done", done_seen - d0, 0);
        full_frame();
        idle(2);

        // Overlong line, then a short line, each in its own frame
        frame_start();
        send_line(H + 1, 2);
        for (int l = 1; l < V; l++) send_line(H, 2);
        idle(1);
        frame_start();
        send_line(H - 2, 2);
        for (int l = 1; l < V; l++) send_line(H, 2);
        frame_start();
        full_frame();
        idle(2);

        // Randomized line lengths and gaps
        for (int f = 0; f < 4; f++) begin
            frame_start();
            for (int l = 0; l < V; l++) begin
                send_line(int'($urandom_range(H + 2, H - 3)), int'($urandom_range(3, 1)));
            end
            idle(int'($urandom_range(3, 1)));
        end

        // Reset in the middle of line 1
        frame_start();
        send_line(H, 2);
        send_pixels(3);
        rst = 1'b1;
        #1;
        m_active = 1'b0;
        m_lines  = 0;
        m_err    = 1'b0;
        check_reset_outputs();
        @(negedge video_clk);
        check_reset_outputs();
        rst = 1'b0;
        de  = 1'b0;
        idle(2);
        d0 = done_seen;
        send_line(5, 2);
        send_line(H, 2);
        check_eq("post_rst_no_done", done_seen - d0, 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
